// File: rtl/mul_div_sequencer.sv
// Moore FSM sequencing the iterative multiply/divide unit: LOAD, STEPS shift steps, WRITE HI/LO, FIN.
// Optional divide-by-zero trap (LOAD straight to FIN with a DivZeroEx pulse) is enabled by MULDIV_DIVZERO_TRAP_EN.
module mul_div_sequencer #(
  parameter int STEPS = 32,
  parameter int CNT_W = 6
) (
  input  logic       clck,
  input  logic       rst_n,
  input  logic       start,
  input  logic       is_div,
  input  logic       DivZeroOP,
  output logic [1:0] MulCtrl,
  output logic [1:0] DivCtrl,
  output logic       DivMulCtrl,
  output logic       HILOCtrl,
  output logic       busy,
  output logic       done,
  output logic       DivZeroEx
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STEP,
    ST_WRITE,
    ST_FIN
  } state_e;

  localparam logic [1:0]       CTRL_IDLE = 2'b00;
  localparam logic [1:0]       CTRL_LOAD = 2'b01;
  localparam logic [1:0]       CTRL_STEP = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEPS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               trap_d;

  logic [1:0]         mul_ctrl_q, mul_ctrl_d;
  logic [1:0]         div_ctrl_q, div_ctrl_d;
  logic               div_mul_q, div_mul_d;
  logic               hilo_q, hilo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [1:0]         unit_ctrl;

  // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    trap_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = is_div;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_STEP;
`ifdef MULDIV_DIVZERO_TRAP_EN
        if (op_q && DivZeroOP) begin
          state_d = ST_FIN;
          trap_d  = 1'b1;
        end
`endif
      end
      ST_STEP: begin
        if (cnt_q == CNT_LAST) state_d = ST_WRITE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_WRITE: state_d = ST_FIN;
      ST_FIN: begin
        if (start) begin
          op_d    = is_div;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    unit_ctrl = CTRL_IDLE;
    if (state_d == ST_LOAD)      unit_ctrl = CTRL_LOAD;
    else if (state_d == ST_STEP) unit_ctrl = CTRL_STEP;
    mul_ctrl_d = op_d ? CTRL_IDLE : unit_ctrl;
    div_ctrl_d = op_d ? unit_ctrl : CTRL_IDLE;
    div_mul_d  = (state_d != ST_IDLE) && op_d;
    hilo_d     = (state_d == ST_WRITE);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_STEP) || (state_d == ST_WRITE);
    done_d     = (state_d == ST_FIN);
    div_zero_d = trap_d;
  end

`ifndef MULDIV_DIVZERO_TRAP_EN
  logic unused_div_zero_op;
  assign unused_div_zero_op = DivZeroOP;
`endif

  // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(negedge clck) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      mul_ctrl_q <= CTRL_IDLE;
      div_ctrl_q <= CTRL_IDLE;
      div_mul_q  <= 1'b0;
      hilo_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      mul_ctrl_q <= mul_ctrl_d;
      div_ctrl_q <= div_ctrl_d;
      div_mul_q  <= div_mul_d;
      hilo_q     <= hilo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign MulCtrl    = mul_ctrl_q;
  assign DivCtrl    = div_ctrl_q;
  assign DivMulCtrl = div_mul_q;
  assign HILOCtrl   = hilo_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign DivZeroEx  = div_zero_q;

endmodule
